io_port_bridge: RTL and testbench

//  Device-side end of the CPU's 8-bit I/O ports.
//  - TX path: captures each OUT write (out_port value + out_en_master strobe) into a FIFO and presents it to an external consumer with valid/ready.
//  - RX path: accepts bytes from an external producer with valid/ready into a second FIFO, whose head drives the CPU in_port.
//  - The head of the RX FIFO is popped when the CPU executes IN (id_reg_en).
//  - Sits in the top level between the core and the board/testbench I/O.

---
 rtl/io_port_bridge.sv | 139 +++++++++++++
 tb/tb_io_port_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// Purpose: device-side bridge for the CPU 8-bit I/O ports (OUT writes -> TX FIFO, RX FIFO -> IN reads).
// Latency: show-ahead FIFOs, a push at edge N is on the head outputs right after edge N; reads are zero-latency.
// Backpressure: tx_valid/tx_ready toward the consumer, rx_ready = RX not full toward the producer; TX overflow drops the byte.

module io_port_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Storage, pointers and occupancy; caller guarantees push/pop are legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));
endmodule

module io_port_bridge #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cpu_out_data,
    input  logic             cpu_out_we,
    output logic [WIDTH-1:0] cpu_in_data,
    output logic             cpu_in_valid,
    input  logic             cpu_in_rd,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             tx_full,
    output logic [1:0]       err,
    input  logic             err_clr
);
    logic             w_tx_empty;
    logic             w_tx_full;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic [WIDTH-1:0] w_tx_head;
    logic             w_rx_empty;
    logic             w_rx_full;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic [WIDTH-1:0] w_rx_head;
    logic [1:0]       w_err_new;
    logic [1:0]       r_err;

    // A full TX FIFO still takes a write when the head leaves in the same cycle.
    assign w_tx_pop  = !w_tx_empty && tx_ready;
    assign w_tx_push = cpu_out_we && (!w_tx_full || w_tx_pop);

    // RX readiness comes from the registered count only; no pass-through when full.
    assign w_rx_push = rx_valid && !w_rx_full;
    assign w_rx_pop  = cpu_in_rd && !w_rx_empty;

    io_port_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_tx_push),
        .i_push_dat (cpu_out_data),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full)
    );

    io_port_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rx_push),
        .i_push_dat (rx_data),
        .i_pop      (w_rx_pop),
        .o_head_dat (w_rx_head),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full)
    );

    assign w_err_new[0] = cpu_out_we && w_tx_full && !w_tx_pop;
    assign w_err_new[1] = cpu_in_rd && w_rx_empty;

    // Sticky error flags; a new error in the same cycle wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 2'b00;
        end else begin
            r_err <= (err_clr ? 2'b00 : r_err) | w_err_new;
        end
    end

    assign tx_data      = w_tx_head;
    assign tx_valid     = !w_tx_empty;
    assign tx_full      = w_tx_full;
    assign cpu_in_data  = w_rx_empty ? '0 : w_rx_head;
    assign cpu_in_valid = !w_rx_empty;
    assign rx_ready     = !w_rx_full;
    assign err          = r_err;
endmodule

// File: tb/tb_io_port_bridge.sv
// Purpose: directed self-checking bench for io_port_bridge.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before the next edge.
// Backpressure: exercises TX overflow/full-with-pop and RX full/hold/underflow cases.

module tb_io_port_bridge;
    logic       clk;
    logic       rst;
    logic [7:0] cpu_out_data;
    logic       cpu_out_we;
    logic [7:0] cpu_in_data;
    logic       cpu_in_valid;
    logic       cpu_in_rd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       tx_full;
    logic [1:0] err;
    logic       err_clr;

    int n_checks = 0;
    int n_errors = 0;

    io_port_bridge #(.WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_out_data (cpu_out_data),
        .cpu_out_we   (cpu_out_we),
        .cpu_in_data  (cpu_in_data),
        .cpu_in_valid (cpu_in_valid),
        .cpu_in_rd    (cpu_in_rd),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_full      (tx_full),
        .err          (err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tx_exp [4];

    initial begin
        rst = 1'b1; cpu_out_data = '0; cpu_out_we = 1'b0; cpu_in_rd = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; err_clr = 1'b0;

        // 1. reset and idle
        tick(); tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_in_valid", cpu_in_valid, 0);
        chk("rst_in_data", cpu_in_data, 8'h00);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_err", err, 2'b00);
        rst = 1'b0;
        tick();
        chk("idle_rx_ready", rx_ready, 1);
        chk("idle_err", err, 2'b00);

        // 2. fill TX, overflow, drain
        for (int i = 0; i < 4; i++) begin
            cpu_out_data = 8'h11 * (i + 1);
            cpu_out_we = 1'b1;
            tick();
            if (i == 0) chk("tx_first_visible", tx_data, 8'h11);
        end
        cpu_out_we = 1'b0;
        chk("tx_full_after4", tx_full, 1);
        cpu_out_data = 8'h55; cpu_out_we = 1'b1;
        tick();
        cpu_out_we = 1'b0;
        chk("tx_ovf_err", err, 2'b01);
        chk("tx_ovf_full", tx_full, 1);
        chk("tx_ovf_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain_valid", tx_valid, 1);
            chk("tx_drain_data", tx_data, 8'h11 * (i + 1));
            tick();
        end
        chk("tx_drained", tx_valid, 0);
        tx_ready = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_tx", err, 2'b00);

        // 3. full TX with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            cpu_out_data = 8'h11 * (i + 1);
            cpu_out_we = 1'b1;
            tick();
        end
        cpu_out_data = 8'h66; tx_ready = 1'b1;
        chk("tx_pp_head_before", tx_data, 8'h11);
        tick();
        cpu_out_we = 1'b0; tx_ready = 1'b0;
        chk("tx_pp_full", tx_full, 1);
        chk("tx_pp_err", err, 2'b00);
        chk("tx_pp_head", tx_data, 8'h22);
        tx_exp[0] = 8'h22; tx_exp[1] = 8'h33; tx_exp[2] = 8'h44; tx_exp[3] = 8'h66;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_pp_drain", tx_data, tx_exp[i]);
            tick();
        end
        tx_ready = 1'b0;
        chk("tx_pp_empty", tx_valid, 0);

        // 4. RX fill, producer hold, pop frees space
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hA0 + 8'(i);
            chk("rx_ready_fill", rx_ready, 1);
            tick();
        end
        rx_data = 8'hA4;
        chk("rx_ready_full", rx_ready, 0);
        chk("rx_head_a0", cpu_in_data, 8'hA0);
        tick();
        chk("rx_hold_ready", rx_ready, 0);
        chk("rx_hold_head", cpu_in_data, 8'hA0);
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("rx_space_ready", rx_ready, 1);
        chk("rx_head_a1", cpu_in_data, 8'hA1);
        tick();
        rx_valid = 1'b0;
        chk("rx_a4_taken_full", rx_ready, 0);
        for (int i = 1; i < 5; i++) begin
            chk("rx_read_seq", cpu_in_data, 8'hA0 + 8'(i));
            cpu_in_rd = 1'b1;
            tick();
            cpu_in_rd = 1'b0;
        end
        chk("rx_empty_valid", cpu_in_valid, 0);
        chk("rx_empty_data", cpu_in_data, 8'h00);
        chk("rx_no_err", err, 2'b00);

        // 5. RX underflow, clear, empty push+pop, set-dominance
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("rx_unf_err", err, 2'b10);
        chk("rx_unf_data", cpu_in_data, 8'h00);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("rx_unf_clr", err, 2'b00);
        rx_valid = 1'b1; rx_data = 8'h5A; cpu_in_rd = 1'b1;
        tick();
        rx_valid = 1'b0; cpu_in_rd = 1'b0;
        chk("rx_pp_valid", cpu_in_valid, 1);
        chk("rx_pp_data", cpu_in_data, 8'h5A);
        chk("rx_pp_err", err, 2'b10);
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b1; err_clr = 1'b1;
        tick();
        cpu_in_rd = 1'b0; err_clr = 1'b0;
        chk("err_set_dominant", err, 2'b10);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_final", err, 2'b00);

        // 6. reset mid-stream, then wraparound
        for (int i = 0; i < 3; i++) begin
            cpu_out_we = 1'b1; cpu_out_data = 8'h70 + 8'(i);
            rx_valid = 1'b1; rx_data = 8'hB0 + 8'(i);
            tick();
        end
        cpu_out_we = 1'b0; rx_valid = 1'b0;
        chk("pre_rst_tx_valid", tx_valid, 1);
        chk("pre_rst_in_valid", cpu_in_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_in_valid", cpu_in_valid, 0);
        chk("mid_rst_in_data", cpu_in_data, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_tx_valid", tx_valid, 0);
        chk("post_rst_in_valid", cpu_in_valid, 0);
        chk("post_rst_rx_ready", rx_ready, 1);
        for (int i = 0; i < 10; i++) begin
            cpu_out_we = 1'b1; cpu_out_data = 8'(i * 7 + 3);
            rx_valid = 1'b1; rx_data = 8'(8'hC0 + i);
            tick();
            cpu_out_we = 1'b0; rx_valid = 1'b0;
            chk("wrap_tx_data", tx_data, 8'(i * 7 + 3));
            chk("wrap_rx_data", cpu_in_data, 8'(8'hC0 + i));
            tx_ready = 1'b1; cpu_in_rd = 1'b1;
            tick();
            tx_ready = 1'b0; cpu_in_rd = 1'b0;
            chk("wrap_tx_empty", tx_valid, 0);
            chk("wrap_rx_empty", cpu_in_valid, 0);
        end
        chk("wrap_err", err, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
